rr_onehot_arbiter: RTL and testbench
====================================

RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, number of requesters, legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  NUM_REQ  per-requester request; bit i high means requester i wants the grant.
REQ-005 The block SHALL have port grant  output  NUM_REQ  registered grant vector, one-hot or all-zero.
REQ-006 The block SHALL have port grant_idx  output  $clog2(NUM_REQ)  binary index of the set grant bit; 0 when grant is zero.
REQ-007 The block SHALL have port grant_valid  output  1  high exactly when grant is non-zero.

Function
REQ-008 The block SHALL keep an internal pointer ptr holding the index of the last granted requester.
REQ-009 Arbitration SHALL select the first set bit of req found by searching upward from ptr+1, wrapping modulo NUM_REQ, and ending at ptr itself.
REQ-010 Outputs SHALL be registered: req sampled at edge k determines grant, grant_idx and grant_valid visible after edge k (1-cycle latency).
REQ-011 On a granting edge, ptr SHALL update to the granted index.
REQ-012 When req is all-zero, grant SHALL become zero, grant_valid 0, grant_idx 0, and ptr SHALL be unchanged.
REQ-013 At every cycle, grant SHALL have zero or one bit set, with grant_valid equal to the OR of grant and grant[grant_idx] equal to grant_valid.
REQ-014 The search SHALL wrap correctly: with ptr = NUM_REQ-1, bit 0 has highest priority.
REQ-015 A requester SHALL never wait more than NUM_REQ-1 grants while its req stays high (starvation-free).
REQ-016 The grant SHALL be independent of req bits other than the selected one, beyond the priority order in REQ-009.

Reset
REQ-017 While reset is high at a rising edge, the block SHALL set grant = 0, grant_valid = 0, grant_idx = 0 and ptr = NUM_REQ-1, regardless of req.
REQ-018 Reset asserted mid-grant SHALL drop the grant at that edge.
REQ-019 After reset deasserts, the first arbitration SHALL favour requester 0.

Configuration
REQ-020 With macro RR_ARB_LOCK_EN defined, the block SHALL keep grant, grant_idx and ptr unchanged for as long as grant_valid is 1 and req[grant_idx] stays high.
REQ-021 With RR_ARB_LOCK_EN defined, the block SHALL re-arbitrate per REQ-009 at the first edge where the held requester's req bit is low.
REQ-022 Without RR_ARB_LOCK_EN, the block SHALL re-arbitrate on every edge, so a continuously requesting grantee is rotated away whenever another requester is active.

Structure
REQ-023 Package rr_arb_pkg SHALL hold the default NUM_REQ constant, the index-width function/constant, and a pure function converting a one-hot vector to a binary index.
REQ-024 The block SHALL instantiate one combinational sub-module rr_pick (inputs: req, ptr; outputs: one-hot pick, pick index, pick valid) containing the wrapped priority search.
REQ-025 rr_onehot_arbiter SHALL contain only the registers, the lock logic and the ptr update.

Verification (NUM_REQ = 4)
REQ-026 No lock, req = 4'b1111 held after reset: grant SHALL step through 0001, 0010, 0100, 1000, 0001 on successive cycles.
REQ-027 req = 0000 for 3 cycles then 0100: grant SHALL stay 0000 with grant_valid 0, then become 0100 with grant_idx 2 one cycle after req changes.
REQ-028 Wrap: last grant 1000 (ptr = 3), then req = 1001: next grant SHALL be 0001, and the following grant SHALL be 1000.
REQ-029 RR_ARB_LOCK_EN, req = 1111: grant SHALL hold 0001 while the bits stay high; after req changes to 1110, grant SHALL become 0010 on the next edge.
REQ-030 Reset mid-operation: with grant = 0100, pulsing reset for 1 cycle with req = 1111 SHALL give grant 0000 at the reset edge, then 0001 on the next edge.
REQ-031 A bench checker SHALL confirm on every cycle, over 10k cycles of random req, that grant is one-hot or zero, that REQ-013 holds, and that REQ-015 holds.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin one-hot arbiter.
//   NUM_REQ_DEFAULT : default number of requesters
//   MAX_REQ         : largest supported requester count
//   idx_width()     : width of a binary requester index
//   onehot_to_idx() : binary index of the set bit of a one-hot vector
//                     (0 for an all-zero vector)
package rr_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 8;
    localparam int MAX_REQ         = 32;
    localparam int MAX_IDX_W       = 5;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // OR-ing the indices of every set bit gives the right answer for a
    // one-hot input and 0 for an all-zero one, without a priority chain.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational wrapped priority search.
// Starting just above ptr and wrapping modulo NUM_REQ (ptr itself is
// examined last), selects the first requester whose req bit is set.
// Ports:
//   req        in  [NUM_REQ-1:0] request vector
//   ptr        in  [IW-1:0]      index of the last granted requester
//   pick       out [NUM_REQ-1:0] one-hot selected requester, zero if none
//   pick_idx   out [IW-1:0]      binary index of pick, 0 if none
//   pick_valid out               some requester is selected
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      pick_idx,
    output logic               pick_valid
);

    always_comb begin
        logic found;
        int   j;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign pick_valid = |req;
    assign pick_idx   = IW'(onehot_to_idx(MAX_REQ'(pick)));

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant.
// req sampled at a rising edge decides the grant visible after that edge.
// ptr remembers the last granted index; the next search starts above it,
// so every active requester is served within NUM_REQ-1 grants.
// Optional feature: define RR_ARB_LOCK_EN to keep the current grant for
// as long as the granted requester keeps its req bit high.
// Ports:
//   clk         in                 clock, rising edge
//   reset       in                 synchronous, active-high
//   req         in  [NUM_REQ-1:0]  request vector
//   grant       out [NUM_REQ-1:0]  one-hot or zero grant
//   grant_idx   out [IW-1:0]       binary index of grant, 0 if none
//   grant_valid out                grant is non-zero
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int IW     = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    logic [IW-1:0]      ptr;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               hold;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

`ifdef RR_ARB_LOCK_EN
    // grant_idx is only used as an index while grant_valid is high, so it
    // always addresses an existing requester here.
    assign hold = grant_valid && req[grant_idx];
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            // Starting at the top index makes requester 0 the first choice.
            ptr         <= IW'(NUM_REQ - 1);
        end else if (hold) begin
            grant       <= grant;
            grant_idx   <= grant_idx;
            grant_valid <= grant_valid;
            ptr         <= ptr;
        end else if (pick_valid) begin
            grant       <= pick;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            ptr         <= pick_idx;
        end else begin
            // Idle: drop the grant but keep the rotation position.
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter with NUM_REQ = 4.
// The driver applies req/reset on the falling edge and queues the response
// expected after the next rising edge; the monitor, 1 time unit after each
// rising edge, pops and compares it and also checks the grant invariants
// and the starvation bound on every cycle.
module tb_rr_onehot_arbiter;

    localparam int N = 4;
    localparam int W = 7;  // {valid, idx[1:0], grant[3:0]}

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         grant_valid;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;

    rr_onehot_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- helpers ----------------
    function automatic logic [1:0] oh2i(input logic [N-1:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] pack(input logic [N-1:0] g);
        return {|g, oh2i(g), g};
    endfunction

    // Reference search: scan a doubled request vector upward from ptr+1.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   g;
        dbl = {r, r};
        for (int k = 1; k <= N; k++) begin
            if (dbl[p + k]) begin
                g = '0;
                g[(p + k) % N] = 1'b1;
                return g;
            end
        end
        return '0;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic [N-1:0] r, input logic [N-1:0] g);
        @(negedge clk);
        reset = rst;
        req   = r;
        exp_q.push_back(pack(g));
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [N-1:0] req_e;
    logic         rst_e;
    logic [N-1:0] prev_grant;
    int           wait_cnt[N];

    always @(posedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        logic         new_grant;
        int           worst;
        req_e = req;
        rst_e = reset;
        #1;
        act_v = {grant_valid, grant_idx, grant};

        // grant invariants
        n_checks++;
        if (((grant & (grant - 1'b1)) != '0) || (grant_valid != |grant) ||
            (grant[grant_idx] != grant_valid) || (!grant_valid && grant_idx != 2'd0)) begin
            n_errors++;
            $display("FAIL invariant: grant=%b idx=%0d valid=%b", grant, grant_idx, grant_valid);
        end

        // starvation bound: count new grants to others while a request is held
        new_grant = grant_valid && (grant != prev_grant);
        worst = 0;
        for (int i = 0; i < N; i++) begin
            if (rst_e || !req_e[i] || grant[i]) begin
                wait_cnt[i] = 0;
            end else if (new_grant) begin
                wait_cnt[i] = wait_cnt[i] + 1;
            end
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        n_checks++;
        if (worst > N - 1) begin
            n_errors++;
            $display("FAIL starvation: wait=%0d limit=%0d", worst, N - 1);
        end
        prev_grant = grant;

        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL grant_seq: req=%b got v/idx/grant=%b/%0d/%b want %b/%0d/%b",
                         req_e, act_v[6], act_v[5:4], act_v[3:0],
                         exp_v[6], exp_v[5:4], exp_v[3:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int           mptr;
        logic [N-1:0] mg;
        logic [N-1:0] r;
        logic [N-1:0] p;
        n_checks   = 0;
        n_errors   = 0;
        prev_grant = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        reset = 1'b1;
        req   = 4'b1111;

`ifndef RR_ARB_LOCK_EN
        drive(1'b1, 4'b1111, 4'b0000);  // reset state
        // full rotation
        drive(1'b0, 4'b1111, 4'b0001);
        drive(1'b0, 4'b1111, 4'b0010);
        drive(1'b0, 4'b1111, 4'b0100);
        drive(1'b0, 4'b1111, 4'b1000);
        drive(1'b0, 4'b1111, 4'b0001);
        // idle then single request
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0100, 4'b0100);
        // wrap from ptr = 3
        drive(1'b0, 4'b1000, 4'b1000);
        drive(1'b0, 4'b1001, 4'b0001);
        drive(1'b0, 4'b1001, 4'b1000);
        // reset mid-grant
        drive(1'b0, 4'b0100, 4'b0100);
        drive(1'b1, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0001);
        // sparse patterns
        drive(1'b0, 4'b1010, 4'b0010);
        drive(1'b0, 4'b1010, 4'b1000);
        drive(1'b0, 4'b0110, 4'b0010);
        drive(1'b0, 4'b0001, 4'b0001);
        drive(1'b0, 4'b0001, 4'b0001);
`else
        drive(1'b1, 4'b1111, 4'b0000);  // reset state
        // grant locked while the holder keeps requesting
        drive(1'b0, 4'b1111, 4'b0001);
        drive(1'b0, 4'b1111, 4'b0001);
        drive(1'b0, 4'b1111, 4'b0001);
        drive(1'b0, 4'b1110, 4'b0010);
        drive(1'b0, 4'b1110, 4'b0010);
        drive(1'b0, 4'b1100, 4'b0100);
        drive(1'b0, 4'b0000, 4'b0000);
        drive(1'b0, 4'b1001, 4'b1000);
        drive(1'b0, 4'b1001, 4'b1000);
        drive(1'b1, 4'b1111, 4'b0000);
        drive(1'b0, 4'b1111, 4'b0001);
`endif

        // random phase with reference model
        drive(1'b1, 4'b0000, 4'b0000);
        mptr = N - 1;
        mg   = '0;
        for (int c = 0; c < 10000; c++) begin
            r = 4'($urandom_range(0, 15));
`ifdef RR_ARB_LOCK_EN
            if (mg != '0 && (r & mg) != '0) begin
                drive(1'b0, r, mg);
                continue;
            end
`endif
            p = model_pick(r, mptr);
            if (p != '0) mptr = int'(oh2i(p));
            mg = p;
            drive(1'b0, r, p);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
